// File: rtl/dram_bank_ctrl.sv
// Single-bank DRAM timing model: one open row, tRCD/tRAS/tWR/precharge enforcement,
// and an internal row array that holds the bank contents.
module dram_bank_ctrl #(
  parameter int DATA_WIDTH       = 64,
  parameter int NUM_ROWS         = 100,
  parameter int ADDRESS_LEN      = 10,
  parameter int TRCD_CYCLES      = 10,
  parameter int TRAS_CYCLES      = 22,
  parameter int TWR_CYCLES       = 7,
  parameter int PRECHARGE_CYCLES = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDRESS_LEN-1:0] req_row,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   resp_valid,
  output logic                   resp_err,
  output logic [DATA_WIDTH-1:0]  resp_rdata,
  output logic                   open_row_valid,
  output logic [ADDRESS_LEN-1:0] open_row
);

  localparam int IDX_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int RAS_W   = $clog2(TRAS_CYCLES + 1);
  localparam int WR_W    = $clog2(TWR_CYCLES + 1);
  localparam int TMR_MAX = (PRECHARGE_CYCLES > TRCD_CYCLES) ? PRECHARGE_CYCLES : TRCD_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [RAS_W-1:0]     RAS_SAT   = RAS_W'(TRAS_CYCLES);
  localparam logic [WR_W-1:0]      WR_SAT    = WR_W'(TWR_CYCLES);
  localparam logic [TMR_W-1:0]     PRE_LOAD  = TMR_W'(PRECHARGE_CYCLES - 1);
  localparam logic [TMR_W-1:0]     RCD_LOAD  = TMR_W'(TRCD_CYCLES - 1);
  localparam logic [ADDRESS_LEN:0] ROW_LIMIT = (ADDRESS_LEN + 1)'(NUM_ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_RAS_WAIT,
    S_PRECHARGING,
    S_ACTIVATING,
    S_ACCESS
  } state_t;

  state_t                 state_q, state_d;
  logic                   wr_q, wr_d;
  logic                   err_q, err_d;
  logic [ADDRESS_LEN-1:0] row_q, row_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [RAS_W-1:0]       ras_cnt_q, ras_cnt_d;
  logic [WR_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   open_row_valid_q, open_row_valid_d;
  logic [ADDRESS_LEN-1:0] open_row_q, open_row_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_err_q, resp_err_d;
  logic                   rd_sel_q, rd_sel_d;

  logic                   accept;
  logic                   req_in_range;
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_idx;
  logic [DATA_WIDTH-1:0]  rd_q;
  logic [DATA_WIDTH-1:0]  mem [NUM_ROWS];

  assign req_ready    = !rst && (state_q == S_IDLE || state_q == S_OPEN);
  assign accept       = req_valid && req_ready;
  assign req_in_range = {1'b0, req_row} < ROW_LIMIT;

  always_comb begin
    state_d          = state_q;
    wr_d             = wr_q;
    err_d            = err_q;
    row_d            = row_q;
    wdata_d          = wdata_q;
    tmr_d            = tmr_q;
    open_row_valid_d = open_row_valid_q;
    open_row_d       = open_row_q;
    ras_cnt_d        = (ras_cnt_q == RAS_SAT) ? ras_cnt_q : ras_cnt_q + RAS_W'(1);
    wr_cnt_d         = (wr_cnt_q == WR_SAT) ? wr_cnt_q : wr_cnt_q + WR_W'(1);
    resp_valid_d     = (state_q == S_ACCESS);
    resp_err_d       = (state_q == S_ACCESS) && err_q;
    rd_sel_d         = (state_q == S_ACCESS) && !wr_q && !err_q;

    case (state_q)
      S_IDLE, S_OPEN: begin
        if (accept) begin
          wr_d    = req_write;
          row_d   = req_row;
          wdata_d = req_wdata;
          err_d   = !req_in_range;
          // Out-of-range requests bypass the row machinery entirely.
          if (!req_in_range) begin
            state_d = S_ACCESS;
          end else if (state_q == S_IDLE) begin
            state_d          = S_ACTIVATING;
            tmr_d            = RCD_LOAD;
            open_row_valid_d = 1'b1;
            open_row_d       = req_row;
            ras_cnt_d        = '0;
          end else if (req_row == open_row_q) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_RAS_WAIT;
          end
        end
      end
      S_RAS_WAIT: begin
        if (ras_cnt_q == RAS_SAT && wr_cnt_q == WR_SAT) begin
          state_d          = S_PRECHARGING;
          tmr_d            = PRE_LOAD;
          open_row_valid_d = 1'b0;
        end
      end
      S_PRECHARGING: begin
        if (tmr_q == '0) begin
          state_d          = S_ACTIVATING;
          tmr_d            = RCD_LOAD;
          open_row_valid_d = 1'b1;
          open_row_d       = row_q;
          ras_cnt_d        = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_ACTIVATING: begin
        if (tmr_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_ACCESS: begin
        // An error from IDLE leaves no row open, so fall back to IDLE.
        state_d = open_row_valid_q ? S_OPEN : S_IDLE;
        if (wr_q && !err_q) begin
          wr_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      wr_q             <= 1'b0;
      err_q            <= 1'b0;
      row_q            <= '0;
      wdata_q          <= '0;
      ras_cnt_q        <= '0;
      wr_cnt_q         <= WR_SAT;
      tmr_q            <= '0;
      open_row_valid_q <= 1'b0;
      open_row_q       <= '0;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      rd_sel_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_q             <= wr_d;
      err_q            <= err_d;
      row_q            <= row_d;
      wdata_q          <= wdata_d;
      ras_cnt_q        <= ras_cnt_d;
      wr_cnt_q         <= wr_cnt_d;
      tmr_q            <= tmr_d;
      open_row_valid_q <= open_row_valid_d;
      open_row_q       <= open_row_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      rd_sel_q         <= rd_sel_d;
    end
  end

  // Bank array: no reset, registered read; output masked unless the access was a read.
  assign mem_idx = row_q[IDX_W-1:0];
  assign mem_we  = (state_q == S_ACCESS) && wr_q && !err_q && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= wdata_q;
    end
    rd_q <= mem[mem_idx];
  end

  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = rd_sel_q ? rd_q : '0;
  assign open_row_valid = open_row_valid_q;
  assign open_row       = open_row_q;

endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Randomized bench for dram_bank_ctrl: a cycle-timeline model derived from the
// bank timing rules predicts every output each cycle; directed cases pin literal latencies.
module tb_dram_bank_ctrl;
  localparam int DW   = 64;
  localparam int NR   = 100;
  localparam int AL   = 10;
  localparam int TRCD = 10;
  localparam int TRAS = 22;
  localparam int TWR  = 7;
  localparam int TPRE = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AL-1:0] req_row = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, resp_valid, resp_err, open_row_valid;
  logic [DW-1:0] resp_rdata;
  logic [AL-1:0] open_row;

  always #5 clk = ~clk;

  dram_bank_ctrl #(
    .DATA_WIDTH(DW), .NUM_ROWS(NR), .ADDRESS_LEN(AL), .TRCD_CYCLES(TRCD),
    .TRAS_CYCLES(TRAS), .TWR_CYCLES(TWR), .PRECHARGE_CYCLES(TPRE)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_row(req_row), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .open_row_valid(open_row_valid), .open_row(open_row)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model state: bank contents plus absolute cycle numbers of upcoming events.
  logic [DW-1:0] m_mem [NR];
  bit            m_known [NR];
  bit            m_ov;
  int            m_orow, m_act, m_lastwr;
  int            ready_from, resp_c, close_c, open_c, commit_c, new_row;
  bit            p_err, p_rd_known;
  logic [DW-1:0] p_rdata;
  bit            pend_wr;
  int            pend_row;
  logic [DW-1:0] pend_data;

  bit            obs_seen;
  int            obs_cyc, obs_last_cyc;
  logic          obs_err;
  logic [DW-1:0] obs_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    if (pend_wr && cyc >= commit_c) begin
      m_mem[pend_row]   = pend_data;
      m_known[pend_row] = 1'b1;
    end
    pend_wr    = 1'b0;
    m_ov       = 1'b0;
    m_orow     = 0;
    m_act      = -1000;
    m_lastwr   = -1000;
    ready_from = 0;
    resp_c     = -1;
    close_c    = -1;
    open_c     = -1;
    commit_c   = -1;
  endfunction

  // e = cycle in which the request was presented and accepted.
  function automatic void model_accept(input int e, input bit wr, input int row, input logic [DW-1:0] d);
    int a, c0;
    bit err;
    err = (row >= NR);
    if (err) begin
      a = e + 1;
    end else if (!m_ov) begin
      open_c  = e + 1;
      new_row = row;
      m_act   = e + 1;
      a       = e + TRCD + 1;
    end else if (row == m_orow) begin
      a = e + 1;
    end else begin
      c0 = e + 1;
      if (m_act + TRAS > c0) c0 = m_act + TRAS;
      if (m_lastwr + TWR + 1 > c0) c0 = m_lastwr + TWR + 1;
      close_c = c0 + 1;
      open_c  = c0 + TPRE + 1;
      new_row = row;
      m_act   = open_c;
      a       = c0 + TPRE + TRCD + 1;
    end
    resp_c     = a + 1;
    ready_from = a + 1;
    p_err      = err;
    p_rdata    = '0;
    p_rd_known = 1'b1;
    if (!err && !wr) begin
      p_rd_known = m_known[row];
      p_rdata    = m_mem[row];
    end
    if (wr && !err) begin
      pend_wr   = 1'b1;
      pend_row  = row;
      pend_data = d;
      commit_c  = a + 1;
      m_lastwr  = a;
    end
  endfunction

  task automatic cycle_check();
    logic exp_rv;
    if (cyc == close_c) m_ov = 1'b0;
    if (cyc == open_c) begin
      m_ov   = 1'b1;
      m_orow = new_row;
    end
    if (pend_wr && cyc == commit_c) begin
      m_mem[pend_row]   = pend_data;
      m_known[pend_row] = 1'b1;
      pend_wr           = 1'b0;
    end
    exp_rv = !rst && (cyc == resp_c);
    chk("req_ready", 64'(req_ready), 64'(!rst && cyc >= ready_from));
    chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
    chk("resp_err", 64'(resp_err), 64'(exp_rv && p_err));
    if (!(exp_rv && !p_rd_known)) chk("resp_rdata", resp_rdata, exp_rv ? p_rdata : 64'd0);
    chk("open_row_valid", 64'(open_row_valid), 64'(m_ov));
    chk("open_row", 64'(open_row), 64'(m_orow));
    if (resp_valid === 1'b1) begin
      obs_seen     = 1'b1;
      obs_cyc      = cyc;
      obs_last_cyc = cyc;
      obs_err      = resp_err;
      obs_rdata    = resp_rdata;
    end
  endtask

  // Advance one cycle: check at the falling edge, then move past the rising edge.
  task automatic step(input bit acc);
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    if (acc) model_accept(cyc, req_write, int'(req_row), req_wdata);
    cyc++;
    #1;
  endtask

  task automatic issue(input bit wr, input int row, input logic [DW-1:0] d, output int e);
    int guard;
    guard = 0;
    while (cyc < ready_from && guard < 200) begin
      step(1'b0);
      guard++;
    end
    req_valid = 1'b1;
    req_write = wr;
    req_row   = AL'(row);
    req_wdata = d;
    e         = cyc;
    step(1'b1);
    req_valid = 1'b0;
    obs_seen  = 1'b0;
    $display("txn cyc=%0d %s row=%0d wdata=%0h", e, wr ? "WR" : "RD", row, d);
  endtask

  task automatic wait_resp();
    for (int k = 0; k < 80 && !obs_seen; k++) step(1'b0);
    chk("resp_seen", 64'(obs_seen), 64'd1);
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    req_valid = 1'b0;
    model_reset();
    repeat (n) step(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int e0, e1;
    int row, mode;
    bit wr;
    logic [DW-1:0] d;
    logic [DW-1:0] v_old;
    for (int i = 0; i < NR; i++) m_known[i] = 1'b0;
    model_reset();
    obs_seen     = 1'b0;
    obs_last_cyc = -1;
    #1;
    step(1'b0);
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_open_valid", 64'(open_row_valid), 64'd0);
    do_reset(2);

    // Read from IDLE, then an immediate miss to row 7 while tRAS is still running.
    issue(1'b0, 5, '0, e0);
    issue(1'b0, 7, '0, e1);
    chk("lat_idle_read", 64'(obs_last_cyc - e0), 64'd12);
    chk("open_row_after_act", 64'(open_row), 64'd5);
    wait_resp();
    chk("lat_miss_tras", 64'(obs_cyc - e1), 64'd33);
    chk("open_row_after_miss", 64'(open_row), 64'd7);

    issue(1'b1, 7, 64'h0000_0000_DEAD_BEEF, e0);
    wait_resp();
    chk("lat_hit_write", 64'(obs_cyc - e0), 64'd2);
    issue(1'b0, 7, '0, e0);
    wait_resp();
    chk("lat_hit_read", 64'(obs_cyc - e0), 64'd2);
    chk("raw_rdata", obs_rdata, 64'h0000_0000_DEAD_BEEF);

    // Write hit followed immediately by a miss: tWR governs the precharge.
    repeat (30) step(1'b0);
    issue(1'b1, 7, 64'hA5A5_0000_5A5A_FFFF, e0);
    issue(1'b0, 9, '0, e1);
    wait_resp();
    chk("lat_miss_twr", 64'(obs_cyc - e1), 64'd29);
    chk("open_row_9", 64'(open_row), 64'd9);

    issue(1'b0, 100, '0, e0);
    wait_resp();
    chk("lat_err", 64'(obs_cyc - e0), 64'd2);
    chk("err_flag", 64'(obs_err), 64'd1);
    chk("err_rdata", obs_rdata, 64'd0);
    chk("err_open_row", 64'(open_row), 64'd9);
    chk("err_open_valid", 64'(open_row_valid), 64'd1);

    // Reset during ACTIVATING of a write: dropped, old data survives.
    v_old = 64'h1234_5678_9ABC_DEF0;
    issue(1'b1, 9, v_old, e0);
    wait_resp();
    do_reset(2);
    issue(1'b1, 9, 64'hFFFF_EEEE_DDDD_CCCC, e0);
    repeat (3) step(1'b0);
    do_reset(2);
    obs_seen = 1'b0;
    repeat (30) step(1'b0);
    chk("no_resp_after_rst", 64'(obs_seen), 64'd0);
    issue(1'b0, 9, '0, e0);
    wait_resp();
    chk("lat_after_rst", 64'(obs_cyc - e0), 64'd12);
    chk("old_data_kept", obs_rdata, v_old);

    // Randomized traffic; the per-cycle model comparison does the checking.
    for (int t = 0; t < 400; t++) begin
      mode = int'($urandom_range(0, 9));
      if (mode < 7)      row = int'($urandom_range(0, 5));
      else if (mode < 9) row = int'($urandom_range(0, NR - 1));
      else               row = ($urandom_range(0, 3) == 0) ? 1023 : int'($urandom_range(NR - 5, 130));
      wr = 1'($urandom_range(0, 1));
      d  = {$urandom, $urandom};
      issue(wr, row, d, e0);
      repeat ($urandom_range(0, 3)) step(1'b0);
      if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(0, 25)) step(1'b0);
        do_reset(int'($urandom_range(1, 2)));
      end
    end
    repeat (40) step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
